// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem
//   AXI4 memory responder for one crossbar slave port. It serves a single
//   transaction at a time from an internal word-addressed RAM and alternates
//   between write and read requests when both are pending. FIXED, INCR and
//   WRAP bursts are supported, as are byte strobes and SLVERR responses.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   aw* / awvalid / awready       write address channel
//   wdata wstrb wlast / wvalid / wready   write data channel
//   bid bresp / bvalid / bready   write response channel
//   ar* / arvalid / arready       read address channel
//   rid rdata rresp rlast / rvalid / rready   read data channel
//
// FSM states
//   state | meaning
//   IDLE  | no transaction, arbitrating between AW and AR
//   WDATA | accepting write beats
//   WRESP | holding the B response until bready
//   RDATA | presenting read beats until the last one is taken

module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t                  state;
  logic                    prefer_write;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              beat_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            sz,
    input logic [7:0]            ln,
    input logic [1:0]            bt
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] wmask;
    inc   = a + (ADDR_WIDTH'(1) << sz);
    // wrap block is (len+1) beats of 2^size bytes, aligned to its own size
    wmask = ((ADDR_WIDTH'(ln) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    case (bt)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~wmask) | (inc & wmask);
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic beat_err(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            sz,
    input logic [7:0]            ln,
    input logic [1:0]            bt
  );
    logic [ADDR_WIDTH-1:0] off;
    logic                  bad_wrap;
    off      = a - BASE_ADDR;
    bad_wrap = (bt == 2'b10) &&
               !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15);
    beat_err = (a < BASE_ADDR) ||
               ((off >> LG) >= ADDR_WIDTH'(MEM_DEPTH)) ||
               ((1 << sz) > STRB_W) ||
               bad_wrap ||
               (bt == 2'b11);
  endfunction

  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off     = a - BASE_ADDR;
    mem_idx = IDX_W'(off >> LG);
  endfunction

  assign awready = !rst && (state == IDLE) && awvalid && (!arvalid || prefer_write);
  assign arready = !rst && (state == IDLE) && arvalid && (!awvalid || !prefer_write);
  assign wready  = !rst && (state == WDATA);

  logic                  w_fire;
  logic                  w_err;
  logic                  w_bad;
  logic [ADDR_WIDTH-1:0] w_next;

  assign w_fire = wvalid && wready;
  assign w_err  = beat_err(addr_q, size_q, len_q, burst_q);
  assign w_bad  = w_err || (wlast != (beat_q == len_q));
  assign w_next = next_addr(addr_q, size_q, len_q, burst_q);

  // Read lookup: in IDLE this is the first beat of the incoming AR, in RDATA
  // it is the beat after the current one, so rdata can be registered.
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            rd_size;
  logic [7:0]            rd_len;
  logic [1:0]            rd_burst;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_addr  = araddr;
    rd_size  = arsize;
    rd_len   = arlen;
    rd_burst = arburst;
    if (state == RDATA) begin
      rd_addr  = next_addr(addr_q, size_q, len_q, burst_q);
      rd_size  = size_q;
      rd_len   = len_q;
      rd_burst = burst_q;
    end
    rd_err  = beat_err(rd_addr, rd_size, rd_len, rd_burst);
    rd_word = rd_err ? '0 : mem[mem_idx(rd_addr)];
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[mem_idx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prefer_write <= 1'b1;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      bvalid       <= 1'b0;
      bid          <= '0;
      bresp        <= OKAY;
      rvalid       <= 1'b0;
      rid          <= '0;
      rdata        <= '0;
      rresp        <= OKAY;
      rlast        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid && awready) begin
            id_q         <= awid;
            addr_q       <= awaddr;
            len_q        <= awlen;
            size_q       <= awsize;
            burst_q      <= awburst;
            beat_q       <= '0;
            err_q        <= 1'b0;
            prefer_write <= ~prefer_write;
            state        <= WDATA;
          end else if (arvalid && arready) begin
            id_q         <= arid;
            addr_q       <= araddr;
            len_q        <= arlen;
            size_q       <= arsize;
            burst_q      <= arburst;
            beat_q       <= '0;
            prefer_write <= ~prefer_write;
            rvalid       <= 1'b1;
            rid          <= arid;
            rdata        <= rd_word;
            rresp        <= rd_err ? SLVERR : OKAY;
            rlast        <= (arlen == 8'd0);
            state        <= RDATA;
          end
        end
        WDATA: begin
          if (w_fire) begin
            if (w_bad) err_q <= 1'b1;
            if (beat_q == len_q) begin
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err_q || w_bad) ? SLVERR : OKAY;
              state  <= WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= w_next;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RDATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              state  <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= rd_addr;
              rdata  <= rd_word;
              rresp  <= rd_err ? SLVERR : OKAY;
              rlast  <= ((beat_q + 8'd1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: a reference memory model produces
// the expected B and R payloads, a negedge monitor compares them (also on
// every stalled cycle) against the front of the scoreboard queues.

module tb_axi4_slave_mem;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;
  logic          rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi4_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH), .BASE_ADDR('0)
  ) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
    logic [DW-1:0] data;
  } r_exp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  logic [7:0]  glog[$];
  logic [31:0] model_mem [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [2:0] sz,
                                         input logic [7:0] ln, input logic [1:0] bt, input int i);
    logic [31:0] bytes, blk, lo;
    bytes = 32'd1 << sz;
    case (bt)
      2'b00: return a;
      2'b10: begin
        blk = (32'(ln) + 32'd1) * bytes;
        lo  = a - (a % blk);
        return lo + (((a - lo) + 32'(i) * bytes) % blk);
      end
      default: return a + 32'(i) * bytes;
    endcase
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz,
                               input logic [7:0] ln, input logic [1:0] bt);
    bit wrap_bad;
    wrap_bad = (bt == 2'b10) && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15);
    return (a >= 32'(DEPTH * 4)) || (sz > 3'd2) || (bt == 2'b11) || wrap_bad;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid && awready) glog.push_back(8'h57);
      if (arvalid && arready) glog.push_back(8'h52);
      if (rvalid) begin
        if (exp_r.size() == 0) check_val("r_unexpected", 64'(rvalid), 64'd0);
        else begin
          check_val("r_beat", 64'({rid, rresp, rlast, rdata}), 64'(exp_r[0]));
          if (rready) void'(exp_r.pop_front());
        end
      end
      if (bvalid) begin
        if (exp_b.size() == 0) check_val("b_unexpected", 64'(bvalid), 64'd0);
        else begin
          check_val("b_resp", 64'({bid, bresp}), 64'(exp_b[0]));
          if (bready) void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] d0, input logic [3:0] strb);
    logic [31:0] a, wd;
    bit          any_err;
    bit          hs;
    int          n;
    b_exp_t      e;
    any_err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      a  = m_addr(addr, size, len, burst, i);
      wd = d0 + 32'(i);
      if (m_err(a, size, len, burst)) any_err = 1;
      else for (int b = 0; b < 4; b++) if (strb[b]) model_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    end
    e.id   = id;
    e.resp = any_err ? 2'b10 : 2'b00;
    exp_b.push_back(e);

    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin n++; @(negedge clk); end
    check_val("aw_grant", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = d0 + 32'(i); wstrb = strb; wlast = (i == int'(len));
      @(negedge clk);
      check_val("wready", 64'(wready), 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("b_latency", 64'(bvalid), 64'd1);
    hs = bvalid && bready;
    @(posedge clk); #1;
    n = 0;
    while (!hs && n < 60) begin
      bready = (n > 3) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = bvalid && bready;
      @(posedge clk); #1;
      n++;
    end
    bready = 1'b0;
    check_val("b_done", 64'(hs), 64'd1);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit throttle);
    logic [31:0] a;
    bit          e_err;
    r_exp_t      e;
    int          n, n_hs, cyc;
    bit          first;
    for (int i = 0; i <= int'(len); i++) begin
      a      = m_addr(addr, size, len, burst, i);
      e_err  = m_err(a, size, len, burst);
      e.id   = id;
      e.resp = e_err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      e.data = e_err ? 32'd0 : model_mem[a[11:2]];
      exp_r.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin n++; @(negedge clk); end
    check_val("ar_grant", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n_hs = 0; cyc = 0; first = 1;
    while (n_hs <= int'(len) && cyc < 600) begin
      rready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (first || !throttle) check_val("r_valid", 64'(rvalid), 64'd1);
      first = 0;
      if (rvalid && rready) n_hs++;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    check_val("r_beats", 64'(n_hs), 64'(int'(len) + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] order;
    r_exp_t      e0;
    int          n;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_val("reset_ctl", 64'({awready, wready, arready, bvalid, rvalid, bid, bresp, rid, rresp, rlast}), 64'd0);
    check_val("reset_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;

    // both requests pending whenever the slave is idle: grants must alternate
    arid = 4'h7; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    do_write(4'h3, 32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF);
    awid = 4'h1; awaddr = 32'h20; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    do_read(4'h7, 32'h10, 8'd3, 3'd2, 2'b01, 1'b1);
    arid = 4'h2; araddr = 32'h20; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    do_write(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF);
    do_read(4'h2, 32'h20, 8'd0, 3'd2, 2'b01, 1'b1);
    check_val("arb_count", 64'(glog.size()), 64'd4);
    order = '0;
    for (int i = 0; i < 4 && i < glog.size(); i++) order = {order[23:0], glog[i]};
    check_val("arb_order", 64'(order), 64'("WRWR"));

    // byte strobes over the 0xFFFFFFFF word
    do_write(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, 32'h1122_3344, 4'b0101);
    do_read(4'h4, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);

    // wrap read over RAM[12..15] = 12..15
    do_write(4'h2, 32'h30, 8'd3, 3'd2, 2'b01, 32'd12, 4'hF);
    do_read(4'h9, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);

    // fixed burst keeps hitting one word
    do_write(4'h0, 32'h80, 8'd2, 3'd2, 2'b00, 32'h77, 4'hF);
    do_read(4'h1, 32'h80, 8'd0, 3'd2, 2'b01, 1'b0);

    // error cases
    do_write(4'h0, 32'h0, 8'd0, 3'd2, 2'b01, 32'h5A5A_5A5A, 4'hF);
    do_write(4'h5, 32'(DEPTH * 4), 8'd0, 3'd2, 2'b01, 32'hDEAD_0000, 4'hF);
    do_read(4'h5, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    do_read(4'h6, 32'h10, 8'd1, 3'd3, 2'b01, 1'b0);
    do_read(4'h6, 32'h10, 8'd0, 3'd2, 2'b11, 1'b0);
    do_read(4'h6, 32'h10, 8'd2, 3'd2, 2'b10, 1'b0);

    // reset in the second cycle of an 8-beat read
    do_write(4'h0, 32'h100, 8'd7, 3'd2, 2'b01, 32'hC0, 4'hF);
    e0.id = 4'hA; e0.resp = 2'b00; e0.last = 1'b0; e0.data = model_mem[64];
    exp_r.push_back(e0);
    arid = 4'hA; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin n++; @(negedge clk); end
    check_val("rst_ar_grant", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_mid", 64'({rvalid, arready, awready, wready, bvalid, rlast, rid, rresp}), 64'd0);
      check_val("rst_mid_rdata", 64'(rdata), 64'd0);
      @(posedge clk); #1;
    end
    do_read(4'hB, 32'h100, 8'd7, 3'd2, 2'b01, 1'b1);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
